chacha_param_loader: RTL and testbench

Byte-serial parameter loader that sits directly upstream of the ChaCha encryption core. It accepts a fixed 48-byte frame over an 8-bit valid/ready stream and assembles the frame into the core's 256-bit key, 32-bit block counter and 96-bit nonce. It then presents the assembled parameter set to the core with a valid/ready handshake. This lets the pin-limited top level load real key material instead of tying those core inputs to zero.

---
 rtl/chacha_param_loader.sv | 102 ++++++++++
 tb/tb_chacha_param_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_param_loader.sv
// Byte-serial loader for the ChaCha core: assembles a 48-byte frame into
// key/counter/nonce and hands it over with a valid/ready handshake.
module chacha_param_loader #(
  parameter int TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [255:0] key,
  output logic [31:0]  counter,
  output logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   byte_cnt,
  output logic         timeout_err
);

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [5:0]  LAST_BYTE = 6'd47;
  localparam logic [16:0] TMO_LIM   = 17'(TIMEOUT);

  state_t         state_q, state_d;
  logic [5:0]     byte_cnt_q, byte_cnt_d;
  logic [15:0]    idle_q, idle_d;
  logic [383:0]   frame_q, frame_d;
  logic           tmo_q, tmo_d;
  logic           accept;
  logic [16:0]    idle_inc;

  assign in_ready = (state_q == LOAD) & ~reset;
  assign accept   = in_valid & in_ready & ~abort;
  assign idle_inc = {1'b0, idle_q} + 17'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      byte_cnt_q <= '0;
      idle_q     <= '0;
      frame_q    <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
      frame_q    <= frame_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = idle_q;
    frame_d    = frame_q;
    tmo_d      = 1'b0;
    case (state_q)
      LOAD: begin
        if (abort) begin
          byte_cnt_d = '0;
          idle_d     = '0;
        end else if (accept) begin
          // Frame is little-endian: key bytes 0..31, counter 32..35, nonce 36..47
          frame_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          idle_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end else if ((TIMEOUT != 0) && (byte_cnt_q != 6'd0)) begin
          if (idle_inc == TMO_LIM) begin
            byte_cnt_d = '0;
            idle_d     = '0;
            tmo_d      = 1'b1;
          end else begin
            idle_d = idle_inc[15:0];
          end
        end
      end
      HOLD: begin
        if (abort || out_ready) begin
          state_d = LOAD;
          idle_d  = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign key         = frame_q[255:0];
  assign counter     = frame_q[287:256];
  assign nonce       = frame_q[383:288];
  assign out_valid   = (state_q == HOLD);
  assign byte_cnt    = byte_cnt_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_chacha_param_loader.sv
// Scoreboard bench for chacha_param_loader: a queue-based frame model predicts
// handshakes and assembled parameters; a negedge monitor checks presented frames.
module tb_chacha_param_loader;

  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         abort = 1'b0;
  logic [255:0] key;
  logic [31:0]  counter;
  logic [95:0]  nonce;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [5:0]   byte_cnt;
  logic         timeout_err;

  chacha_param_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .key(key), .counter(counter),
    .nonce(nonce), .out_valid(out_valid), .out_ready(out_ready),
    .byte_cnt(byte_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: bytes of the partial frame, presentation flag, idle run
  logic [7:0]   m_bytes[$];
  bit           m_hold = 0;
  int           m_idle = 0;
  bit           m_tmo = 0;
  logic [383:0] exp_q[$];
  logic [31:0]  last_ctr;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_hold = 0;
    m_idle = 0;
    m_tmo  = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit ab, input bit ordy);
    logic [383:0] f;
    m_tmo = 0;
    if (!m_hold) begin
      if (ab) begin
        m_bytes.delete();
        m_idle = 0;
      end else if (v) begin
        m_bytes.push_back(d);
        m_idle = 0;
        if (m_bytes.size() == 48) begin
          f = '0;
          for (int i = 0; i < 48; i++) f[8*i +: 8] = m_bytes[i];
          exp_q.push_back(f);
          m_bytes.delete();
          m_hold = 1;
        end
      end else if (m_bytes.size() != 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_bytes.delete();
          m_idle = 0;
          m_tmo  = 1;
        end
      end
    end else if (ab || ordy) begin
      m_hold = 0;
    end
  endtask

  // One clock: drive inputs, predict, step the edge, compare control outputs.
  task automatic tick(input bit v, input logic [7:0] d, input bit ab, input bit ordy);
    in_valid  = v;
    in_data   = d;
    abort     = ab;
    out_ready = ordy;
    model_step(v, d, ab, ordy);
    @(posedge clk);
    #1;
    chk("byte_cnt", 384'(byte_cnt), 384'(m_bytes.size()));
    chk("out_valid", 384'(out_valid), 384'(m_hold));
    chk("in_ready", 384'(in_ready), 384'(!m_hold));
    chk("timeout_err", 384'(timeout_err), 384'(m_tmo));
    if (m_hold) last_ctr = counter;
  endtask

  // Offer bytes with in_valid continuously high until all are accepted.
  task automatic send_stream(input logic [7:0] b[$], input bit ordy);
    int idx = 0;
    int guard = 0;
    while (idx < b.size() && guard < 1000) begin
      if (!m_hold) begin
        tick(1, b[idx], 0, ordy);
        idx++;
      end else begin
        tick(1, b[idx], 0, ordy);
      end
      guard++;
    end
    chk("stream_done", 384'(idx), 384'(b.size()));
  endtask

  // Monitor: every cycle a frame is presented it must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame: out_valid with no expected frame, got %h", {nonce, counter, key});
      end else if ({nonce, counter, key} === exp_q[0]) begin
        n_pass++;
      end else begin
        $display("FAIL frame: got %h expected %h", {nonce, counter, key}, exp_q[0]);
      end
      if ((out_ready || abort) && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq[$];
    logic [7:0] b;
    int cnt;

    #1;
    chk("rst_key", 384'(key), 384'd0);
    chk("rst_out_valid", 384'(out_valid), 384'd0);
    chk("rst_in_ready", 384'(in_ready), 384'd0);
    chk("rst_byte_cnt", 384'(byte_cnt), 384'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // Incrementing frame, out_ready low
    seq.delete();
    for (int i = 0; i < 48; i++) seq.push_back(8'(i));
    send_stream(seq, 0);
    chk("key_lo", 384'(key[31:0]), 384'(32'h03020100));
    chk("key_hi", 384'(key[255:224]), 384'(32'h1F1E1D1C));
    chk("counter", 384'(counter), 384'(32'h23222120));
    chk("nonce_lo", 384'(nonce[31:0]), 384'(32'h27262524));
    chk("nonce_hi", 384'(nonce[95:64]), 384'(32'h2F2E2D2C));
    chk("hold_in_ready", 384'(in_ready), 384'd0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);

    // Same frame, in_valid toggling
    for (int i = 0; i < 48; i++) begin
      tick(1, 8'(i), 0, 0);
      tick(0, 8'hFF, 0, 0);
    end
    chk("tog_key", 384'(key), 384'(256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100));
    chk("tog_counter", 384'(counter), 384'(32'h23222120));
    tick(0, 0, 0, 1);

    // Abort at byte_cnt = 20 with in_valid, then an all-A5 frame
    for (int i = 0; i < 20; i++) tick(1, 8'(i), 0, 0);
    tick(1, 8'h77, 1, 0);
    chk("abort_cnt", 384'(byte_cnt), 384'd0);
    seq.delete();
    for (int i = 0; i < 48; i++) seq.push_back(8'hA5);
    send_stream(seq, 0);
    chk("a5_key", 384'(key), 384'({32{8'hA5}}));
    tick(0, 0, 0, 1);

    // Timeout after 10 bytes
    for (int i = 0; i < 10; i++) tick(1, 8'(i + 100), 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    chk("tmo_pre_cnt", 384'(byte_cnt), 384'd10);
    tick(0, 0, 0, 0);
    chk("tmo_cnt", 384'(byte_cnt), 384'd0);
    chk("tmo_pulse", 384'(timeout_err), 384'd1);
    tick(0, 0, 0, 0);
    chk("tmo_pulse_end", 384'(timeout_err), 384'd0);
    seq.delete();
    for (int i = 0; i < 48; i++) seq.push_back(8'(255 - i));
    send_stream(seq, 0);
    tick(0, 0, 0, 1);

    // Back-to-back with out_ready high
    seq.delete();
    for (int i = 0; i < 96; i++) seq.push_back(8'(i));
    send_stream(seq, 1);
    tick(0, 0, 0, 1);
    chk("b2b_counter", 384'(last_ctr), 384'(32'h53525150));

    // Asynchronous reset at byte_cnt = 30
    for (int i = 0; i < 30; i++) tick(1, 8'(i + 7), 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("arst_key", 384'(key), 384'd0);
    chk("arst_counter", 384'(counter), 384'd0);
    chk("arst_nonce", 384'(nonce), 384'd0);
    chk("arst_byte_cnt", 384'(byte_cnt), 384'd0);
    chk("arst_out_valid", 384'(out_valid), 384'd0);
    chk("arst_in_ready", 384'(in_ready), 384'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    seq.delete();
    for (int i = 0; i < 48; i++) seq.push_back(8'(3 * i + 1));
    send_stream(seq, 0);
    tick(0, 0, 0, 1);

    // Randomized traffic: gaps, occasional aborts, random out_ready
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      b = 8'($urandom_range(0, 255));
      tick(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 99) < 2), ($urandom_range(0, 1) == 1));
      if (m_hold) cnt++;
    end
    tick(0, 0, 0, 1);
    chk("rand_frames_seen", 384'(cnt > 0), 384'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
